// File: rtl/fb_scanout.sv
// Framebuffer scan-out: credit-based VRAM prefetch into a 2-entry FIFO, bit
// accumulator unpacker, h/v pixel replication and palette lookup to registered RGB.
module fb_scanout #(
  parameter int ADDR_W     = 15,
  parameter int VRAM_DEPTH = 22500,
  parameter int SCALE_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               can_color,
  input  logic               line_start,
  input  logic               frame_start,
  input  logic [1:0]         mode,
  input  logic [SCALE_W-1:0] h_scale,
  input  logic [SCALE_W-1:0] v_scale,
  input  logic [ADDR_W-1:0]  line_bytes,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               pal_we,
  input  logic [3:0]         pal_addr,
  input  logic [5:0]         pal_data,
  output logic [ADDR_W-1:0]  vram_addr,
  input  logic [7:0]         vram_data,
  output logic [5:0]         rgb,
  output logic               underrun
);

  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(VRAM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VRAM_DEPTH - 1);

  // Frame configuration, captured on frame_start only
  logic [1:0]         mode_q;
  logic [SCALE_W-1:0] hs_q, vs_q;
  logic [ADDR_W-1:0]  lb_q;

  // Line addressing
  logic [ADDR_W-1:0]  line_base_q, line_base_d;
  logic [SCALE_W-1:0] v_cnt_q, v_cnt_d;
  logic               first_q, first_d;
  logic [ADDR_W:0]    line_sum;
  logic               flush;

  // Prefetch
  logic [ADDR_W-1:0]  fetch_q, fetch_d;
  logic [ADDR_W-1:0]  vaddr_q, vaddr_d;
  logic               rd_valid_q, rd_valid_d;
  logic [7:0]         fifo_mem_q [2];
  logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]         fifo_cnt_q, fifo_cnt_d;
  logic [2:0]         credit;
  logic               issue, push;

  // Accumulator and pixel stage
  logic [15:0]        acc_q, acc_d, acc_shift, append_word;
  logic [4:0]         acc_cnt_q, acc_cnt_d, rem, bpp;
  logic               pop_slot, pop_ok, append;
  logic [SCALE_W-1:0] h_cnt_q, h_cnt_d;
  logic [5:0]         pix_q, pix_d, pix_bits;
  logic               underrun_q, underrun_d;
  logic               act_q;
  logic [5:0]         colour, rgb_q, rgb_d;
  logic [5:0]         pal_q [16];

  assign flush = line_start && !frame_start;

  always_comb begin
    line_sum    = {1'b0, line_base_q} + {1'b0, lb_q};
    line_base_d = line_base_q;
    v_cnt_d     = v_cnt_q;
    first_d     = first_q;
    if (frame_start) begin
      line_base_d = base_addr;
      v_cnt_d     = '0;
      first_d     = 1'b1;
    end else if (line_start) begin
      if (first_q) begin
        first_d = 1'b0;
      end else if (v_cnt_q == vs_q) begin
        v_cnt_d     = '0;
        line_base_d = (line_sum >= DEPTH_X) ? ADDR_W'(line_sum - DEPTH_X) : ADDR_W'(line_sum);
      end else begin
        v_cnt_d = v_cnt_q + SCALE_W'(1);
      end
    end
  end

  always_comb begin
    case (mode_q)
      2'd0:    bpp = 5'd6;
      2'd1:    bpp = 5'd8;
      2'd2:    bpp = 5'd4;
      default: bpp = 5'd2;
    endcase
    case (mode_q)
      2'd0:    pix_bits = acc_q[15:10];
      2'd1:    pix_bits = acc_q[13:8];
      2'd2:    pix_bits = {2'b00, acc_q[15:12]};
      default: pix_bits = {4'b0000, acc_q[15:14]};
    endcase

    pop_slot    = can_color && (h_cnt_q == '0);
    pop_ok      = pop_slot && (acc_cnt_q >= bpp);
    rem         = pop_ok ? (acc_cnt_q - bpp) : acc_cnt_q;
    acc_shift   = pop_ok ? (acc_q << bpp) : acc_q;
    append      = (fifo_cnt_q != 2'd0) && (rem < bpp);
    // Accumulated bits below acc_cnt are always zero, so the new byte can be ORed in.
    append_word = {fifo_mem_q[rd_ptr_q], 8'h00} >> rem;

    acc_d     = append ? (acc_shift | append_word) : acc_shift;
    acc_cnt_d = rem + (append ? 5'd8 : 5'd0);
    if (flush) begin
      acc_d     = '0;
      acc_cnt_d = '0;
    end

    pix_d      = pix_q;
    underrun_d = underrun_q;
    if (pop_slot) begin
      if (pop_ok) begin
        pix_d = pix_bits;
      end else begin
        pix_d      = '0;
        underrun_d = 1'b1;
      end
    end

    if (flush || !can_color || (h_cnt_q == hs_q)) h_cnt_d = '0;
    else                                          h_cnt_d = h_cnt_q + SCALE_W'(1);
  end

  // A byte leaving the FIFO this cycle frees its credit in the same cycle,
  // which is what lets two credits sustain one byte per clock.
  always_comb begin
    push       = rd_valid_q && !flush;
    credit     = {1'b0, fifo_cnt_q} + {2'b00, rd_valid_q} - {2'b00, append};
    issue      = !flush && (credit < 3'd2);
    rd_valid_d = issue;
    vaddr_d    = issue ? fetch_q : vaddr_q;

    if (flush)      fetch_d = line_base_d;
    else if (issue) fetch_d = (fetch_q == LAST_ADDR) ? '0 : fetch_q + ADDR_W'(1);
    else            fetch_d = fetch_q;

    fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, append};
    wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d   = append ? ~rd_ptr_q : rd_ptr_q;
    if (flush) begin
      fifo_cnt_d = '0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
    end
  end

  always_comb begin
    colour = mode_q[1] ? pal_q[pix_q[3:0]] : pix_q;
    rgb_d  = act_q ? colour : 6'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= '0;
      hs_q        <= '0;
      vs_q        <= '0;
      lb_q        <= '0;
      line_base_q <= '0;
      v_cnt_q     <= '0;
      first_q     <= 1'b1;
      fetch_q     <= '0;
      vaddr_q     <= '0;
      rd_valid_q  <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_cnt_q  <= '0;
      acc_q       <= '0;
      acc_cnt_q   <= '0;
      h_cnt_q     <= '0;
      pix_q       <= '0;
      underrun_q  <= 1'b0;
      act_q       <= 1'b0;
      rgb_q       <= '0;
    end else begin
      if (frame_start) begin
        mode_q <= mode;
        hs_q   <= h_scale;
        vs_q   <= v_scale;
        lb_q   <= line_bytes;
      end
      line_base_q <= line_base_d;
      v_cnt_q     <= v_cnt_d;
      first_q     <= first_d;
      fetch_q     <= fetch_d;
      vaddr_q     <= vaddr_d;
      rd_valid_q  <= rd_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      acc_q       <= acc_d;
      acc_cnt_q   <= acc_cnt_d;
      h_cnt_q     <= h_cnt_d;
      pix_q       <= pix_d;
      underrun_q  <= underrun_d;
      act_q       <= can_color;
      rgb_q       <= rgb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= vram_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) pal_q[i] <= '0;
    end else if (pal_we) begin
      pal_q[pal_addr] <= pal_data;
    end
  end

  assign vram_addr = vaddr_q;
  assign rgb       = rgb_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout: a behavioural line model pushes expected
// RGB per active cycle, popped and compared as the DUT produces pixels.
module tb_fb_scanout;
  localparam int ADDR_W  = 15;
  localparam int DEPTH   = 22500;
  localparam int SCALE_W = 3;

  logic               clk = 1'b0;
  logic               rst, can_color, line_start, frame_start, pal_we;
  logic [1:0]         mode;
  logic [SCALE_W-1:0] h_scale, v_scale;
  logic [ADDR_W-1:0]  line_bytes, base_addr, vram_addr;
  logic [3:0]         pal_addr;
  logic [5:0]         pal_data, rgb;
  logic [7:0]         vram_data;
  logic               underrun;

  logic [7:0] mem [DEPTH];
  // Data for an address issued at one edge is on the bus through the next cycle.
  assign vram_data = mem[vram_addr];

  fb_scanout #(.ADDR_W(ADDR_W), .VRAM_DEPTH(DEPTH), .SCALE_W(SCALE_W)) dut (
    .clk(clk), .rst(rst), .can_color(can_color), .line_start(line_start),
    .frame_start(frame_start), .mode(mode), .h_scale(h_scale), .v_scale(v_scale),
    .line_bytes(line_bytes), .base_addr(base_addr), .pal_we(pal_we),
    .pal_addr(pal_addr), .pal_data(pal_data), .vram_addr(vram_addr),
    .vram_data(vram_data), .rgb(rgb), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q [$];

  int cfg_mode, cfg_hs, cfg_vs, cfg_lb, m_base, m_vcnt;
  bit m_first;
  logic [5:0] pal_m [16];

  function automatic int bpp_of(input int m);
    case (m)
      0:       return 6;
      1:       return 8;
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  task automatic push_line(input int base, input int npix);
    int bpp, b, a, a2, v;
    logic [15:0] w;
    logic [5:0] col;
    bpp = bpp_of(cfg_mode);
    for (int k = 0; k < npix; k++) begin
      b  = k * bpp;
      a  = (base + b / 8) % DEPTH;
      a2 = (a + 1) % DEPTH;
      w  = {mem[a], mem[a2]};
      v  = int'(w >> (16 - (b % 8) - bpp)) & ((1 << bpp) - 1);
      case (cfg_mode)
        0:       col = 6'(v);
        1:       col = 6'(v & 63);
        default: col = pal_m[v];
      endcase
      repeat (cfg_hs + 1) exp_q.push_back(col);
    end
  endtask

  task automatic model_line_start();
    if (m_first) m_first = 1'b0;
    else if (m_vcnt == cfg_vs) begin
      m_vcnt = 0;
      m_base = (m_base + cfg_lb) % DEPTH;
    end else m_vcnt++;
  endtask

  task automatic start_frame(input int m, input int hs, input int vs, input int lb, input int base);
    @(negedge clk);
    mode = 2'(m); h_scale = SCALE_W'(hs); v_scale = SCALE_W'(vs);
    line_bytes = ADDR_W'(lb); base_addr = ADDR_W'(base); frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    cfg_mode = m; cfg_hs = hs; cfg_vs = vs; cfg_lb = lb;
    m_base = base; m_vcnt = 0; m_first = 1'b1;
  endtask

  task automatic write_pal(input int a, input logic [5:0] d);
    @(negedge clk);
    pal_we = 1'b1; pal_addr = 4'(a); pal_data = d;
    @(negedge clk);
    pal_we = 1'b0;
    pal_m[a] = d;
  endtask

  // One scanline: line_start at i=0, can_color from i=lead, rgb checked 2 cycles later.
  task automatic run_line(input int lead, input int npix, input int n_addr);
    int active, exp_addr;
    logic [5:0] e;
    model_line_start();
    exp_q.delete();
    push_line(m_base, npix);
    active = npix * (cfg_hs + 1);
    $display("line: base=%0d mode=%0d pixels=%0d cycles=%0d", m_base, cfg_mode, npix, active);
    for (int i = 0; i <= lead + active + 2; i++) begin
      @(negedge clk);
      if (i >= 2 && i < 2 + n_addr) begin
        exp_addr = (m_base + i - 2) % DEPTH;
        checks++;
        if (vram_addr !== ADDR_W'(exp_addr)) begin
          errors++;
          $display("FAIL vram_addr step=%0d got=%0d exp=%0d", i - 2, vram_addr, exp_addr);
        end
      end
      if (i >= lead + 2 && i < lead + active + 2) begin
        e = exp_q.pop_front();
        checks++;
        if (rgb !== e) begin
          errors++;
          $display("FAIL rgb_pixel base=%0d idx=%0d got=%h exp=%h", m_base, i - lead - 2, rgb, e);
        end
      end
      if (i == lead + active + 2) begin
        checks++;
        if (rgb !== 6'd0) begin
          errors++;
          $display("FAIL rgb_blank got=%h exp=00", rgb);
        end
      end
      line_start = (i == 0);
      can_color  = (i >= lead && i < lead + active);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 3;
    if (rgb !== 6'd0) begin errors++; $display("FAIL reset_rgb got=%h exp=00", rgb); end
    if (vram_addr !== '0) begin errors++; $display("FAIL reset_vram_addr got=%0d exp=0", vram_addr); end
    if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) pal_m[i] = '0;
  endtask

  task automatic test_mode0_scale();
    mem[0] = 8'hFC; mem[1] = 8'h0F; mem[2] = 8'hC3;
    mem[3] = 8'h08; mem[4] = 8'h20; mem[5] = 8'h83;
    start_frame(0, 3, 3, 3, 0);
    repeat (5) run_line(4, 4, 1);
  endtask

  task automatic test_mode1_stream();
    for (int i = 0; i < 180; i++) mem[1000 + i] = 8'(i);
    start_frame(1, 0, 0, 180, 1000);
    run_line(4, 180, 1);
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL stream_underrun got=%b exp=0", underrun); end
  endtask

  task automatic test_palette();
    mem[2000] = 8'h12;
    write_pal(1, 6'h30);
    write_pal(2, 6'h0C);
    start_frame(2, 1, 1, 1, 2000);
    run_line(4, 2, 1);
    write_pal(1, 6'h03);
    run_line(4, 2, 1);
    mem[2100] = 8'h1B;
    write_pal(0, 6'h15);
    write_pal(3, 6'h2A);
    start_frame(3, 0, 0, 1, 2100);
    run_line(4, 4, 1);
  endtask

  task automatic test_wrap();
    mem[DEPTH-2] = 8'hA1; mem[DEPTH-1] = 8'hB2; mem[0] = 8'hC3; mem[1] = 8'hD4;
    start_frame(1, 0, 0, 4, DEPTH - 2);
    run_line(4, 4, 4);
    run_line(4, 4, 4);
  endtask

  task automatic test_config_latch();
    for (int i = 0; i < 16; i++) mem[3000 + i] = 8'(8'h55 + 8'(i * 7));
    for (int i = 0; i < 8; i++) mem[3100 + i] = 8'(8'h21 + 8'(i * 9));
    start_frame(1, 0, 0, 8, 3000);
    @(negedge clk);
    mode = 2'd2; h_scale = 3'd3; line_bytes = 15'd40; base_addr = 15'd7;
    run_line(4, 8, 1);
    run_line(4, 8, 1);
    @(negedge clk);
    mode = 2'd1; h_scale = 3'd1; v_scale = 3'd0; line_bytes = 15'd8; base_addr = 15'd3100;
    frame_start = 1'b1; line_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0; line_start = 1'b0;
    cfg_mode = 1; cfg_hs = 1; cfg_vs = 0; cfg_lb = 8;
    m_base = 3100; m_vcnt = 0; m_first = 1'b1;
    run_line(4, 4, 1);
  endtask

  task automatic test_underrun();
    for (int i = 0; i < 24; i++) mem[4000 + i] = 8'h3F - 8'(i);
    start_frame(1, 0, 0, 8, 4000);
    model_line_start();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        checks += 2;
        if (rgb !== 6'd0) begin errors++; $display("FAIL starved_pixel got=%h exp=00", rgb); end
        if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set got=%b exp=1", underrun); end
      end
      line_start = (i == 0);
      can_color  = (i >= 1 && i < 7);
    end
    run_line(4, 8, 1);
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky got=%b exp=1", underrun); end
  endtask

  task automatic test_reset_midline();
    logic [5:0] e;
    model_line_start();
    exp_q.delete();
    push_line(m_base, 8);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 6 || i == 7) begin
        e = exp_q.pop_front();
        checks++;
        if (rgb !== e) begin errors++; $display("FAIL pre_reset_pixel got=%h exp=%h", rgb, e); end
      end
      if (i == 9) begin
        checks += 3;
        if (rgb !== 6'd0) begin errors++; $display("FAIL midreset_rgb got=%h exp=00", rgb); end
        if (vram_addr !== '0) begin errors++; $display("FAIL midreset_vram_addr got=%0d exp=0", vram_addr); end
        if (underrun !== 1'b0) begin errors++; $display("FAIL midreset_underrun got=%b exp=1->0", underrun); end
      end
      line_start = (i == 0);
      can_color  = (i >= 4 && i < 8);
      rst        = (i == 8);
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) pal_m[i] = '0;
    for (int i = 0; i < 4; i++) mem[4100 + i] = 8'h12 + 8'(i * 17);
    start_frame(2, 0, 0, 4, 4100);
    run_line(4, 8, 1);
  endtask

  initial begin
    rst = 1'b1; can_color = 1'b0; line_start = 1'b0; frame_start = 1'b0;
    mode = '0; h_scale = '0; v_scale = '0; line_bytes = '0; base_addr = '0;
    pal_we = 1'b0; pal_addr = '0; pal_data = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    test_reset();
    test_mode0_scale();
    test_mode1_stream();
    test_palette();
    test_wrap();
    test_config_latch();
    test_underrun();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Parametrised framebuffer scan-out engine: the next generation of the graphic-mode pixel path. It sits between `vga_gen` and the render port of the VRAM. It fetches packed pixel bytes through a credit-based prefetch FIFO and unpacks them at 6, 8, 4 or 2 bits per pixel, with palette lookup for the indexed modes. Pixels are replicated by independent runtime horizontal and vertical scale factors, and the block drives registered 6-bit RGB.

## Interface
Parameters:
- `ADDR_W`, 15: VRAM byte address width.
- `VRAM_DEPTH`, 22500: bytes of VRAM. Fetch addresses wrap from `VRAM_DEPTH-1` to 0.
- `SCALE_W`, 3: width of the scale fields. A field value n means n+1 repetitions.

Ports:
- `clk` in 1: pixel clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `can_color` in 1: active-video flag from `vga_gen`.
- `line_start` in 1: one-cycle pulse during h-blank, at least 4 cycles before `can_color` rises.
- `frame_start` in 1: one-cycle pulse during v-blank.
- `mode` in 2: pixel format select. 0 = 6bpp direct, 4 px per 3 bytes, MSB-first. 1 = 8bpp direct, uses bits [5:0]. 2 = 4bpp palette. 3 = 2bpp palette, indices 0-3.
- `h_scale` in SCALE_W: horizontal repeat minus 1.
- `v_scale` in SCALE_W: vertical repeat minus 1.
- `line_bytes` in ADDR_W: source bytes per scanline.
- `base_addr` in ADDR_W: frame start address.
- `pal_we` in 1, `pal_addr` in 4, `pal_data` in 6: palette write port.
- `vram_addr` out ADDR_W: render-port read address. The VRAM returns data 1 cycle later.
- `vram_data` in 8: render-port read data.
- `rgb` out 6: {r1,r0,g1,g0,b1,b0}. Registered.
- `underrun` out 1: sticky flag, set when a pixel was due but fewer than bpp bits were available.

## Operation
- Config latch: `mode`, both scales, `line_bytes` and `base_addr` are captured only on `frame_start` (and to 0 on reset). Input changes mid-frame do not affect the current frame.
- Line addressing:
  - `frame_start` sets `line_base<=base_addr`, `v_cnt<=0`, `first_line<=1`.
  - A `line_start` with `first_line` set clears `first_line` and does not advance.
  - Otherwise, if `v_cnt==v_scale`: `v_cnt<=0` and `line_base<=line_base+line_bytes`, with modulo `VRAM_DEPTH` wrap.
  - Otherwise `v_cnt<=v_cnt+1` and `line_base` is unchanged, so the same source line is replayed.
  - `frame_start` and `line_start` in the same cycle: `frame_start` wins and `line_start` is ignored.
- Line restart: `line_start` flushes the FIFO and the accumulator, resets `h_cnt` and sets `fetch_addr` to the (new) `line_base`. Any read in flight during the flush cycle is discarded when it returns.
- Prefetch:
  - The FIFO holds 2 entries.
  - A read is issued (`vram_addr<=fetch_addr`, `fetch_addr++` with wrap) whenever occupancy plus in-flight reads is less than 2.
  - Fetching continues through blanking. Surplus bytes are discarded at the next flush.
- Accumulator:
  - 16-bit, MSB-aligned, with a bit count `acc_cnt`.
  - Each cycle it appends one FIFO byte if (`acc_cnt` minus the bits popped this cycle) is less than bpp and the FIFO is non-empty.
  - A pop reads the pre-append top bpp bits.
- Pixel timing:
  - While `can_color` is high, `h_cnt` counts 0..`h_scale`.
  - A pop happens on every cycle with `h_cnt==0` into `pix`, which is held for the whole group.
  - If `acc_cnt<bpp` at a pop: `pix<=0` and `underrun<=1`.
  - `can_color` low holds `h_cnt` at 0.
- Colour mapping:
  - Modes 0 and 1 output the pixel bits directly (mode 1 uses byte bits [5:0]).
  - Modes 2 and 3 output `palette[index]`.
  - Palette writes take effect on the next cycle. A read of the same entry in the write cycle returns the old value.

## Timing
- Reset values:
  - Outputs: `rgb=0`, `vram_addr=0`, `underrun=0`.
  - Palette: all entries 0.
  - Internal: FIFO empty, `acc_cnt=0`, `first_line=1`, `v_cnt=0`, `h_cnt=0`, config latched as 0.
- Latency: `can_color` high at cycle t gives `rgb` for the first pixel at t+2. `can_color` low at t gives `rgb=0` at t+2.
- Throughput: sustained 8 bits per cycle at `h_scale=0` in every mode, with no underrun provided the 4-cycle `line_start` lead is honoured.
- `vram_addr` changes only in issue cycles. The returned byte is captured exactly 1 cycle after issue.

## Test plan
- Mode 0, scales 3/3, bytes 0xFC,0x0F,0xC3 at `base_addr` 0 -> rgb sequence 0x3F,0x00,0x3F,0x03, each held 4 cycles. The same line is repeated on 4 consecutive lines, and the 5th line starts at address `line_bytes`.
- Mode 1, `h_scale=0`, 180 bytes 0x00..0xB3, active 180 cycles -> rgb equals byte[5:0] every cycle, starting 2 cycles after `can_color` rises; `underrun` stays 0.
- Mode 2, palette[1]=0x30, palette[2]=0x0C, byte 0x12 -> 0x30 then 0x0C. A palette write of entry 1 to 0x03 before the next line gives 0x03 on that line.
- Wrap: `base_addr=VRAM_DEPTH-2`, mode 1 -> reads addresses 22498, 22499, 0, 1; `line_base` wraps the same way.
- Changing `mode` and `h_scale` mid-frame -> no change until after the next `frame_start`. `frame_start` coincident with `line_start` -> first line at `base_addr`.
- `line_start` only 1 cycle before `can_color`, mode 1 -> `underrun=1`, the starved pixel is black, and the flag stays set until `rst`. `rst` mid-line -> all reset values on the next cycle.
